// File: rtl/wb_bus_if_pkg.sv
// Shared definitions for the CPU-port to Wishbone B3 bridge: FSM state
// encodings, default bus widths, stall vector width and timeout error word.
package wb_bus_if_pkg;

  typedef enum logic [1:0] {
    WB_IDLE           = 2'b00,
    WB_BUSY           = 2'b01,
    WB_WAIT_FOR_STALL = 2'b10
  } wb_state_t;

  localparam int          WB_ADDR_W        = 32;
  localparam int          WB_DATA_W        = 32;
  localparam int          STALL_W          = 6;
  localparam logic [31:0] TIMEOUT_ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/wb_bus_if.sv
// Bridges a single-cycle CPU memory port onto a Wishbone B3 master bus.
// Optional watchdog (adds err_o) is enabled by defining WB_TIMEOUT_EN.
module wb_bus_if
  import wb_bus_if_pkg::*;
#(
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DATA_W = WB_DATA_W
`ifdef WB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STALL_W-1:0]    stall_i,
  input  logic                  flush_i,
  input  logic                  cpu_ce_i,
  input  logic [ADDR_W-1:0]     cpu_addr_i,
  input  logic [DATA_W-1:0]     cpu_data_i,
  input  logic                  cpu_we_i,
  input  logic [DATA_W/8-1:0]   cpu_sel_i,
  output logic [DATA_W-1:0]     cpu_data_o,
  output logic                  stallreq_o,
  input  logic [DATA_W-1:0]     wb_data_i,
  input  logic                  wb_ack_i,
  output logic [ADDR_W-1:0]     wb_addr_o,
  output logic [DATA_W-1:0]     wb_data_o,
  output logic                  wb_we_o,
  output logic [DATA_W/8-1:0]   wb_sel_o,
  output logic                  wb_stb_o,
  output logic                  wb_cyc_o
`ifdef WB_TIMEOUT_EN
  ,
  output logic                  err_o
`endif
);

  wb_state_t             state_reg, state_next;
  logic [DATA_W-1:0]     rd_buf_reg, rd_buf_next;
  logic [ADDR_W-1:0]     wb_addr_next;
  logic [DATA_W-1:0]     wb_data_next;
  logic                  wb_we_next;
  logic [DATA_W/8-1:0]   wb_sel_next;
  logic                  wb_stb_next;
  logic                  wb_cyc_next;

`ifdef WB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             timeout_hit;

  // The last wait cycle before the limit is the timeout cycle itself.
  assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_next   = state_reg;
    rd_buf_next  = rd_buf_reg;
    wb_addr_next = wb_addr_o;
    wb_data_next = wb_data_o;
    wb_we_next   = wb_we_o;
    wb_sel_next  = wb_sel_o;
    wb_stb_next  = wb_stb_o;
    wb_cyc_next  = wb_cyc_o;
    stallreq_o   = 1'b0;
    cpu_data_o   = '0;
`ifdef WB_TIMEOUT_EN
    cnt_next     = cnt_reg;
    err_o        = 1'b0;
`endif

    case (state_reg)
      WB_IDLE: begin
        if (cpu_ce_i && !flush_i) begin
          stallreq_o   = 1'b1;
          wb_addr_next = cpu_addr_i;
          wb_data_next = cpu_data_i;
          wb_we_next   = cpu_we_i;
          wb_sel_next  = cpu_sel_i;
          wb_stb_next  = 1'b1;
          wb_cyc_next  = 1'b1;
          state_next   = WB_BUSY;
`ifdef WB_TIMEOUT_EN
          cnt_next     = '0;
`endif
        end
      end

      WB_BUSY: begin
        if (flush_i || wb_ack_i
`ifdef WB_TIMEOUT_EN
            || timeout_hit
`endif
           ) begin
          wb_addr_next = '0;
          wb_data_next = '0;
          wb_we_next   = 1'b0;
          wb_sel_next  = '0;
          wb_stb_next  = 1'b0;
          wb_cyc_next  = 1'b0;
          state_next   = WB_IDLE;
        end
        // Flush wins over ack: the returned data is simply dropped.
        if (flush_i) begin
          state_next = WB_IDLE;
        end else if (wb_ack_i) begin
          cpu_data_o  = wb_data_i;
          rd_buf_next = wb_data_i;
          state_next  = (stall_i == '0) ? WB_IDLE : WB_WAIT_FOR_STALL;
        end
`ifdef WB_TIMEOUT_EN
        else if (timeout_hit) begin
          cpu_data_o = DATA_W'(TIMEOUT_ERR_DATA);
          err_o      = 1'b1;
        end
`endif
        else begin
          stallreq_o = 1'b1;
`ifdef WB_TIMEOUT_EN
          cnt_next   = cnt_reg + 1'b1;
`endif
        end
      end

      WB_WAIT_FOR_STALL: begin
        cpu_data_o = rd_buf_reg;
        if (stall_i == '0 || flush_i) begin
          state_next = WB_IDLE;
        end
      end

      default: state_next = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= WB_IDLE;
      rd_buf_reg <= '0;
      wb_addr_o  <= '0;
      wb_data_o  <= '0;
      wb_we_o    <= 1'b0;
      wb_sel_o   <= '0;
      wb_stb_o   <= 1'b0;
      wb_cyc_o   <= 1'b0;
`ifdef WB_TIMEOUT_EN
      cnt_reg    <= '0;
`endif
    end else begin
      state_reg  <= state_next;
      rd_buf_reg <= rd_buf_next;
      wb_addr_o  <= wb_addr_next;
      wb_data_o  <= wb_data_next;
      wb_we_o    <= wb_we_next;
      wb_sel_o   <= wb_sel_next;
      wb_stb_o   <= wb_stb_next;
      wb_cyc_o   <= wb_cyc_next;
`ifdef WB_TIMEOUT_EN
      cnt_reg    <= cnt_next;
`endif
    end
  end

endmodule

// File: tb/tb_wb_bus_if.sv
// Directed self-checking bench for wb_bus_if; timeout scenario runs only
// when WB_TIMEOUT_EN is defined (built with TIMEOUT_CYCLES=4).
module tb_wb_bus_if;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  stall_i = '0;
  logic        flush_i = 1'b0;
  logic        cpu_ce_i = 1'b0;
  logic [31:0] cpu_addr_i = '0;
  logic [31:0] cpu_data_i = '0;
  logic        cpu_we_i = 1'b0;
  logic [3:0]  cpu_sel_i = '0;
  logic [31:0] cpu_data_o;
  logic        stallreq_o;
  logic [31:0] wb_data_i = '0;
  logic        wb_ack_i = 1'b0;
  logic [31:0] wb_addr_o;
  logic [31:0] wb_data_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
`ifdef WB_TIMEOUT_EN
  logic        err_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_bus_if #(
    .ADDR_W(32),
    .DATA_W(32)
`ifdef WB_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(4)
`endif
  ) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .cpu_ce_i(cpu_ce_i), .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .cpu_we_i(cpu_we_i), .cpu_sel_i(cpu_sel_i), .cpu_data_o(cpu_data_o),
    .stallreq_o(stallreq_o), .wb_data_i(wb_data_i), .wb_ack_i(wb_ack_i),
    .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o)
`ifdef WB_TIMEOUT_EN
    ,
    .err_o(err_o)
`endif
  );

  // Each cycle: inputs change just after the falling edge, outputs are sampled 1ns later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic quiet_inputs();
    cpu_ce_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0; cpu_sel_i = '0;
    wb_ack_i = 1'b0; wb_data_i = '0; flush_i = 1'b0; stall_i = '0;
  endtask

  task automatic request(input logic [31:0] addr, input logic we, input logic [3:0] sel,
                         input logic [31:0] data);
    next_cycle();
    quiet_inputs();
    cpu_ce_i = 1'b1; cpu_addr_i = addr; cpu_we_i = we; cpu_sel_i = sel; cpu_data_i = data;
    #1;
    checks++;
    if (stallreq_o !== 1'b1) begin errors++; $display("FAIL req_stallreq got=%b exp=1", stallreq_o); end
    checks++;
    if (wb_cyc_o !== 1'b0) begin errors++; $display("FAIL req_cyc got=%b exp=0", wb_cyc_o); end
  endtask

  task automatic test_reset();
    quiet_inputs();
    rst = 1'b0;
    #3;
    checks++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o, wb_data_o, cpu_data_o, stallreq_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs cyc=%b stb=%b addr=%h data=%h cpu_data=%h exp=all zero",
               wb_cyc_o, wb_stb_o, wb_addr_o, wb_data_o, cpu_data_o);
    end
    repeat (2) next_cycle();
    rst = 1'b1;
    next_cycle();
    #1;
    checks++;
    if (wb_cyc_o !== 1'b0 || stallreq_o !== 1'b0) begin
      errors++; $display("FAIL reset_idle cyc=%b stallreq=%b exp=0 0", wb_cyc_o, stallreq_o);
    end
    $display("reset: done");
  endtask

  task automatic test_read();
    request(32'h100, 1'b0, 4'hF, 32'h0);
    // BUSY cycles 1 and 2: no ack, ce dropped (must not cancel)
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      cpu_ce_i = 1'b0;
      #1;
      checks++;
      if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b1 || wb_addr_o !== 32'h100 || wb_we_o !== 1'b0) begin
        errors++;
        $display("FAIL read_wait cyc=%b stb=%b addr=%h we=%b exp=1 1 00000100 0",
                 wb_cyc_o, wb_stb_o, wb_addr_o, wb_we_o);
      end
      checks++;
      if (stallreq_o !== 1'b1) begin errors++; $display("FAIL read_wait_stallreq got=%b exp=1", stallreq_o); end
    end
    next_cycle();
    wb_ack_i = 1'b1; wb_data_i = 32'h12345678;
    #1;
    checks++;
    if (cpu_data_o !== 32'h12345678 || stallreq_o !== 1'b0 || wb_cyc_o !== 1'b1) begin
      errors++;
      $display("FAIL read_ack cpu_data=%h stallreq=%b cyc=%b exp=12345678 0 1", cpu_data_o, stallreq_o, wb_cyc_o);
    end
    next_cycle();
    quiet_inputs();
    #1;
    checks++;
    if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || wb_addr_o !== 32'h0 || cpu_data_o !== 32'h0 || stallreq_o !== 1'b0) begin
      errors++;
      $display("FAIL read_after cyc=%b stb=%b addr=%h cpu_data=%h stallreq=%b exp=0 0 0 0 0",
               wb_cyc_o, wb_stb_o, wb_addr_o, cpu_data_o, stallreq_o);
    end
    $display("read: addr=00000100 data=12345678");
  endtask

  task automatic test_write();
    request(32'h200, 1'b1, 4'b0011, 32'hAABBCCDD);
    next_cycle();
    cpu_ce_i = 1'b0; wb_ack_i = 1'b1;
    #1;
    checks++;
    if (wb_we_o !== 1'b1 || wb_sel_o !== 4'b0011 || wb_data_o !== 32'hAABBCCDD || wb_cyc_o !== 1'b1 || wb_addr_o !== 32'h200) begin
      errors++;
      $display("FAIL write_bus we=%b sel=%b data=%h cyc=%b addr=%h exp=1 0011 aabbccdd 1 00000200",
               wb_we_o, wb_sel_o, wb_data_o, wb_cyc_o, wb_addr_o);
    end
    checks++;
    if (stallreq_o !== 1'b0) begin errors++; $display("FAIL write_ack_stallreq got=%b exp=0", stallreq_o); end
    next_cycle();
    quiet_inputs();
    #1;
    checks++;
    if (wb_cyc_o !== 1'b0 || wb_we_o !== 1'b0 || wb_sel_o !== 4'b0 || wb_data_o !== 32'h0) begin
      errors++;
      $display("FAIL write_after cyc=%b we=%b sel=%b data=%h exp=0 0 0000 0", wb_cyc_o, wb_we_o, wb_sel_o, wb_data_o);
    end
    $display("write: addr=00000200 sel=0011 data=aabbccdd");
  endtask

  task automatic test_read_stall();
    request(32'h300, 1'b0, 4'hF, 32'h0);
    next_cycle();
    cpu_ce_i = 1'b0; wb_ack_i = 1'b1; wb_data_i = 32'hCAFEF00D; stall_i = 6'b000111;
    #1;
    checks++;
    if (cpu_data_o !== 32'hCAFEF00D) begin errors++; $display("FAIL stall_ack_data got=%h exp=cafef00d", cpu_data_o); end
    // three held-stall cycles: data must come from the internal buffer
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      wb_ack_i = 1'b0; wb_data_i = 32'h0; stall_i = 6'b000111; cpu_ce_i = (i == 2);
      #1;
      checks++;
      if (cpu_data_o !== 32'hCAFEF00D || stallreq_o !== 1'b0 || wb_cyc_o !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d] cpu_data=%h stallreq=%b cyc=%b exp=cafef00d 0 0", i, cpu_data_o, stallreq_o, wb_cyc_o);
      end
    end
    next_cycle();
    stall_i = '0; cpu_ce_i = 1'b0;
    #1;
    checks++;
    if (cpu_data_o !== 32'hCAFEF00D) begin errors++; $display("FAIL stall_release_data got=%h exp=cafef00d", cpu_data_o); end
    next_cycle();
    #1;
    checks++;
    if (cpu_data_o !== 32'h0 || wb_cyc_o !== 1'b0) begin
      errors++; $display("FAIL stall_idle cpu_data=%h cyc=%b exp=0 0", cpu_data_o, wb_cyc_o);
    end
    $display("read_stall: addr=00000300 data=cafef00d stall=000111");
  endtask

  task automatic test_flush();
    request(32'h400, 1'b0, 4'hF, 32'h0);
    next_cycle();
    cpu_ce_i = 1'b0; flush_i = 1'b1;
    #1;
    checks++;
    if (stallreq_o !== 1'b0 || wb_cyc_o !== 1'b1) begin
      errors++; $display("FAIL flush_cycle stallreq=%b cyc=%b exp=0 1", stallreq_o, wb_cyc_o);
    end
    next_cycle();
    flush_i = 1'b0; wb_ack_i = 1'b1; wb_data_i = 32'h55555555;
    #1;
    checks++;
    if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || cpu_data_o !== 32'h0 || stallreq_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_late_ack cyc=%b stb=%b cpu_data=%h stallreq=%b exp=0 0 0 0",
               wb_cyc_o, wb_stb_o, cpu_data_o, stallreq_o);
    end
    next_cycle();
    quiet_inputs();
    #1;
    checks++;
    if (wb_cyc_o !== 1'b0 || cpu_data_o !== 32'h0) begin
      errors++; $display("FAIL flush_after cyc=%b cpu_data=%h exp=0 0", wb_cyc_o, cpu_data_o);
    end
    $display("flush: addr=00000400 aborted");
  endtask

  task automatic test_async_reset();
    request(32'h500, 1'b1, 4'hF, 32'h11223344);
    next_cycle();
    cpu_ce_i = 1'b0;
    #1;
    checks++;
    if (wb_cyc_o !== 1'b1 || wb_addr_o !== 32'h500) begin
      errors++; $display("FAIL areset_busy cyc=%b addr=%h exp=1 00000500", wb_cyc_o, wb_addr_o);
    end
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o, wb_data_o, cpu_data_o} !== '0) begin
      errors++;
      $display("FAIL areset_clear cyc=%b stb=%b we=%b addr=%h data=%h cpu_data=%h exp=all zero",
               wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_data_o, cpu_data_o);
    end
    next_cycle();
    rst = 1'b1;
    wb_ack_i = 1'b1;
    #1;
    checks++;
    if (stallreq_o !== 1'b0 || cpu_data_o !== 32'h0 || wb_cyc_o !== 1'b0) begin
      errors++; $display("FAIL areset_idle stallreq=%b cpu_data=%h cyc=%b exp=0 0 0", stallreq_o, cpu_data_o, wb_cyc_o);
    end
    next_cycle();
    quiet_inputs();
    $display("async_reset: addr=00000500 aborted by reset");
  endtask

`ifdef WB_TIMEOUT_EN
  task automatic test_timeout();
    request(32'h600, 1'b0, 4'hF, 32'h0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      cpu_ce_i = 1'b0;
      #1;
      checks++;
      if (err_o !== 1'b0 || stallreq_o !== 1'b1 || wb_cyc_o !== 1'b1) begin
        errors++; $display("FAIL timeout_wait[%0d] err=%b stallreq=%b cyc=%b exp=0 1 1", i, err_o, stallreq_o, wb_cyc_o);
      end
    end
    next_cycle();
    #1;
    checks++;
    if (err_o !== 1'b1 || cpu_data_o !== 32'hDEADBEEF || stallreq_o !== 1'b0 || wb_cyc_o !== 1'b1) begin
      errors++;
      $display("FAIL timeout_hit err=%b cpu_data=%h stallreq=%b cyc=%b exp=1 deadbeef 0 1",
               err_o, cpu_data_o, stallreq_o, wb_cyc_o);
    end
    next_cycle();
    #1;
    checks++;
    if (err_o !== 1'b0 || wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin
      errors++; $display("FAIL timeout_after err=%b cyc=%b stb=%b exp=0 0 0", err_o, wb_cyc_o, wb_stb_o);
    end
    $display("timeout: addr=00000600 no ack");
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_write();
    test_read_stall();
    test_flush();
    test_async_reset();
`ifdef WB_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
